// File: rtl/digit_serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_ndig(input int width, input int digit);
        return (digit > 0) ? (width / digit) : 1;
    endfunction

    // Counter must index NDIG digits; a one-digit operation still needs one bit.
    function automatic int calc_cntw(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder, one slice of the serial datapath.
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] out,
    output logic             cout
);

    logic [DIGIT:0] carry_s;

    // Ripple the carry through every bit of the digit.
    always_comb begin
        carry_s    = '0;
        out        = '0;
        carry_s[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            out[i]       = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
        cout = carry_s[DIGIT];
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, start/busy/done handshake,
// carry/borrow on cout and two's-complement overflow on ovf.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = calc_ndig(WIDTH, DIGIT);
    localparam int CW   = calc_cntw(NDIG);
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $error("digit_serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    state_t           state_r;
    state_t           state_next_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] a_next_s;
    logic [DIGIT-1:0] sum_s;
    logic             carry_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic             busy_r;
    logic             done_r;
    logic             cout_r;
    logic             ovf_r;
    logic             dig_cout_s;
    logic             accept_s;
    logic             last_s;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a    (a_r[DIGIT-1:0]),
        .b    (b_r[DIGIT-1:0]),
        .cin  (carry_r),
        .out  (sum_s),
        .cout (dig_cout_s)
    );

    // Handshake decode; A doubles as the result shift register, sums enter at the top.
    always_comb begin
        accept_s = start && ((state_r == IDLE) || (state_r == DONE));
        last_s   = (state_r == CALC) && (cnt_r == LAST_CNT);
        a_next_s = WIDTH'({sum_s, a_r} >> DIGIT);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = CALC;
                else       state_next_s = IDLE;
            end
            CALC: begin
                if (cnt_r == LAST_CNT) state_next_s = DONE;
                else                   state_next_s = CALC;
            end
            DONE: begin
                if (start) state_next_s = CALC;
                else       state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == CALC);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Operand capture, per-digit shift/accumulate and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            out_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept_s) begin
            // Subtract as a + ~b + 1, with cin turning the +1 into a borrow.
            cnt_r   <= '0;
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= cin ^ sub;
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1] ^ sub;
        end else if (state_r == CALC) begin
            cnt_r   <= last_s ? '0 : (cnt_r + CW'(1));
            a_r     <= a_next_s;
            b_r     <= b_r >> DIGIT;
            carry_r <= dig_cout_s;
            if (last_s) begin
                out_r  <= a_next_s;
                cout_r <= dig_cout_s;
                ovf_r  <= (a_msb_r == b_msb_r) && (a_next_s[WIDTH-1] != a_msb_r);
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign out  = out_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule
